// File: rtl/fbc_serial_resolver_if.sv
// ---------------------------------------------------------------------------
// fbc_serial_resolver_if
//   Bundles the operand/start handshake, the result handshake and the result
//   fields of fbc_serial_resolver.
//
//   Handshake semantics (both channels): a transfer happens on a rising clock
//   edge where valid and ready are both 1. A producer holds its payload stable
//   while valid=1 and ready=0. On the start channel the operands are sampled
//   only on the transfer edge. On the result channel GT/LT/EQ/DIFF_INDEX stay
//   stable from the rise of o_RESULT_VALID until the transfer edge.
//
//   Signals
//     i_START_VALID / o_START_READY   start handshake
//     i_OPERAND_A / i_OPERAND_B       operands (DATA_WIDTH bits)
//     o_RESULT_VALID / i_RESULT_READY result handshake
//     o_A_GT_B / o_A_LT_B / o_A_EQ_B  unsigned relation, one-hot while valid
//     o_DIFF_INDEX                    index of the most-significant differing bit
//     o_BUSY                          resolver is scanning or holding a result
//     o_STATE                         FSM state (debug visibility)
//   Modports: master = operand source / result sink, slave = the resolver.
// ---------------------------------------------------------------------------
interface fbc_serial_resolver_if #(
  parameter int DATA_WIDTH = 16
);
  localparam int IDX_W = $clog2(DATA_WIDTH);

  logic                  i_START_VALID;
  logic                  o_START_READY;
  logic [DATA_WIDTH-1:0] i_OPERAND_A;
  logic [DATA_WIDTH-1:0] i_OPERAND_B;
  logic                  o_RESULT_VALID;
  logic                  i_RESULT_READY;
  logic                  o_A_GT_B;
  logic                  o_A_LT_B;
  logic                  o_A_EQ_B;
  logic [IDX_W-1:0]      o_DIFF_INDEX;
  logic                  o_BUSY;
  logic [1:0]            o_STATE;

  modport master (
    output i_START_VALID, i_OPERAND_A, i_OPERAND_B, i_RESULT_READY,
    input  o_START_READY, o_RESULT_VALID, o_A_GT_B, o_A_LT_B, o_A_EQ_B,
           o_DIFF_INDEX, o_BUSY, o_STATE
  );

  modport slave (
    input  i_START_VALID, i_OPERAND_A, i_OPERAND_B, i_RESULT_READY,
    output o_START_READY, o_RESULT_VALID, o_A_GT_B, o_A_LT_B, o_A_EQ_B,
           o_DIFF_INDEX, o_BUSY, o_STATE
  );
endinterface

// File: rtl/fbc_serial_resolver.sv
// ---------------------------------------------------------------------------
// fbc_serial_resolver
//   Sequential unsigned magnitude resolver. Captures two DATA_WIDTH-bit
//   operands on the start handshake, then scans one nibble per cycle from the
//   MSB nibble down. Each nibble's XOR is turned into a one-hot
//   first-difference vector and decoded into GT/LT/EQ plus the bit index of
//   the first difference. The result is presented on a valid/ready channel.
//
//   Ports
//     i_CLK    clock, rising edge
//     i_RST_N  asynchronous active-low reset
//     bus      fbc_serial_resolver_if.slave (handshakes, operands, results)
//
//   Parameter
//     DATA_WIDTH  operand width, multiple of 4 and >= 4 (bus must match)
//
//   Build option
//     FBC_EARLY_EXIT_EN  defined: SCAN ends at the first differing nibble.
//                        undefined: SCAN always visits all nibbles
//                        (constant time); the first difference is latched.
// ---------------------------------------------------------------------------
module fbc_serial_resolver #(
  parameter int DATA_WIDTH = 16
) (
  input  logic                  i_CLK,
  input  logic                  i_RST_N,
  fbc_serial_resolver_if.slave  bus
);
  localparam int N     = DATA_WIDTH / 4;
  localparam int IDX_W = $clog2(DATA_WIDTH);
  localparam int KW    = (N > 1) ? $clog2(N) : 1;
  localparam logic [KW-1:0] K_TOP = KW'(N - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] a_q, b_q;
  logic [KW-1:0]         k_q;
  logic                  valid_q, gt_q, lt_q, eq_q;
  logic [IDX_W-1:0]      idx_q;

  // Current nibble decode
  logic [3:0]            a_nib, x, h;
  logic [1:0]            p;
  logic                  hit_now, a_bit;
  logic [IDX_W-1:0]      idx_now;

  // Result produced by this SCAN cycle (valid when fin=1)
  logic                  fin, fin_gt, fin_lt, fin_eq;
  logic [IDX_W-1:0]      fin_idx;

`ifndef FBC_EARLY_EXIT_EN
  // First difference seen so far in constant-time mode
  logic                  found_q, pend_gt_q;
  logic [IDX_W-1:0]      pend_idx_q;
`endif

  always_comb begin
    a_nib = a_q[{k_q, 2'b00} +: 4];
    x     = a_nib ^ b_q[{k_q, 2'b00} +: 4];
    // One-hot first-difference vector, MSB priority
    h[3]  = x[3];
    h[2]  = ~x[3] & x[2];
    h[1]  = ~x[3] & ~x[2] & x[1];
    h[0]  = ~x[3] & ~x[2] & ~x[1] & x[0];
    p     = 2'd0;
    if (h[3])      p = 2'd3;
    else if (h[2]) p = 2'd2;
    else if (h[1]) p = 2'd1;
    hit_now = |h;
    a_bit   = a_nib[p];
    // 4k+p is the concatenation {k, p}
    idx_now = IDX_W'({k_q, p});
  end

  always_comb begin
    state_d = state_q;
    fin     = 1'b0;
    fin_gt  = 1'b0;
    fin_lt  = 1'b0;
    fin_eq  = 1'b0;
    fin_idx = '0;
    case (state_q)
      IDLE: if (bus.i_START_VALID) state_d = SCAN;
      SCAN: begin
`ifdef FBC_EARLY_EXIT_EN
        if (hit_now) begin
          fin     = 1'b1;
          fin_gt  = a_bit;
          fin_lt  = ~a_bit;
          fin_idx = idx_now;
        end else if (k_q == '0) begin
          fin    = 1'b1;
          fin_eq = 1'b1;
        end
`else
        if (k_q == '0) begin
          fin = 1'b1;
          if (found_q) begin
            fin_gt  = pend_gt_q;
            fin_lt  = ~pend_gt_q;
            fin_idx = pend_idx_q;
          end else if (hit_now) begin
            fin_gt  = a_bit;
            fin_lt  = ~a_bit;
            fin_idx = idx_now;
          end else begin
            fin_eq = 1'b1;
          end
        end
`endif
        if (fin) state_d = DONE;
      end
      DONE: if (bus.i_RESULT_READY) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_CLK or negedge i_RST_N) begin
    if (!i_RST_N) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_ff @(posedge i_CLK or negedge i_RST_N) begin
    if (!i_RST_N) begin
      a_q        <= '0;
      b_q        <= '0;
      k_q        <= '0;
      valid_q    <= 1'b0;
      gt_q       <= 1'b0;
      lt_q       <= 1'b0;
      eq_q       <= 1'b0;
      idx_q      <= '0;
`ifndef FBC_EARLY_EXIT_EN
      found_q    <= 1'b0;
      pend_gt_q  <= 1'b0;
      pend_idx_q <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: if (bus.i_START_VALID) begin
          a_q     <= bus.i_OPERAND_A;
          b_q     <= bus.i_OPERAND_B;
          k_q     <= K_TOP;
`ifndef FBC_EARLY_EXIT_EN
          found_q <= 1'b0;
`endif
        end
        SCAN: begin
`ifndef FBC_EARLY_EXIT_EN
          if (!found_q && hit_now) begin
            found_q    <= 1'b1;
            pend_gt_q  <= a_bit;
            pend_idx_q <= idx_now;
          end
`endif
          if (fin) begin
            valid_q <= 1'b1;
            gt_q    <= fin_gt;
            lt_q    <= fin_lt;
            eq_q    <= fin_eq;
            idx_q   <= fin_idx;
          end else begin
            k_q <= k_q - KW'(1);
          end
        end
        DONE: if (bus.i_RESULT_READY) begin
          // Result fields read as zero whenever no result is offered
          valid_q <= 1'b0;
          gt_q    <= 1'b0;
          lt_q    <= 1'b0;
          eq_q    <= 1'b0;
          idx_q   <= '0;
        end
        default: ;
      endcase
    end
  end

  assign bus.o_START_READY  = (state_q == IDLE);
  assign bus.o_BUSY         = (state_q != IDLE);
  assign bus.o_STATE        = state_q;
  assign bus.o_RESULT_VALID = valid_q;
  assign bus.o_A_GT_B       = gt_q;
  assign bus.o_A_LT_B       = lt_q;
  assign bus.o_A_EQ_B       = eq_q;
  assign bus.o_DIFF_INDEX   = idx_q;
endmodule

// File: tb/tb_fbc_serial_resolver.sv
module tb_fbc_serial_resolver;
  localparam int DW = 16;
  localparam int NIB = DW / 4;

  logic clk;
  logic rst_n;
  int   vectors;
  int   miscompares;
  logic [6:0] exp_q[$];   // {gt, lt, eq, idx[3:0]}

  fbc_serial_resolver_if #(.DATA_WIDTH(DW)) bus ();

  fbc_serial_resolver #(.DATA_WIDTH(DW)) dut (
    .i_CLK   (clk),
    .i_RST_N (rst_n),
    .bus     (bus.slave)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic logic [6:0] model(input logic [DW-1:0] a, input logic [DW-1:0] b);
    logic [DW-1:0] d;
    logic [3:0]    idx;
    d   = a ^ b;
    idx = 4'd0;
    for (int i = 0; i < DW; i++) if (d[i]) idx = i[3:0];
    return {a > b, a < b, a == b, idx};
  endfunction

  function automatic int model_lat(input logic [DW-1:0] a, input logic [DW-1:0] b);
    int top;
    logic [DW-1:0] d;
    d   = a ^ b;
    top = -1;
    for (int i = 0; i < DW; i++) if (d[i]) top = i;
`ifdef FBC_EARLY_EXIT_EN
    if (top < 0) return NIB;
    return NIB - top / 4;
`else
    return NIB;
`endif
  endfunction

  function automatic logic [6:0] observed();
    return {bus.o_A_GT_B, bus.o_A_LT_B, bus.o_A_EQ_B, bus.o_DIFF_INDEX};
  endfunction

  // ---------------- driver ----------------
  // One transaction with the consumer always ready. lat counts rising edges
  // from the accepting edge up to the one that raised o_RESULT_VALID.
  task automatic drive_txn(input logic [DW-1:0] a, input logic [DW-1:0] b,
                           input bit scramble, output logic [6:0] got,
                           output int lat, output bit tmo);
    int w;
    tmo = 1'b0;
    lat = 0;
    got = '0;
    w   = 0;
    while (!bus.o_START_READY && w < 50) begin @(negedge clk); w++; end
    if (!bus.o_START_READY) begin tmo = 1'b1; return; end
    bus.i_OPERAND_A    = a;
    bus.i_OPERAND_B    = b;
    bus.i_RESULT_READY = 1'b1;
    bus.i_START_VALID  = 1'b1;
    @(negedge clk);
    bus.i_START_VALID = 1'b0;
    if (scramble) begin
      bus.i_OPERAND_A = 16'($urandom);
      bus.i_OPERAND_B = 16'($urandom);
    end
    while (!bus.o_RESULT_VALID && lat < 20) begin @(negedge clk); lat++; end
    if (!bus.o_RESULT_VALID) tmo = 1'b1;
    else got = observed();
    @(negedge clk);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    bus.i_START_VALID  = 1'b1;   // must be ignored during reset
    bus.i_OPERAND_A    = 16'h1234;
    bus.i_OPERAND_B    = 16'h4321;
    bus.i_RESULT_READY = 1'b1;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    vectors++;
    if (bus.o_BUSY !== 1'b0) begin
      miscompares++; $display("FAIL reset_busy_in_reset got=%b exp=0", bus.o_BUSY);
    end
    bus.i_START_VALID = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    vectors++;
    if (bus.o_RESULT_VALID !== 1'b0) begin
      miscompares++; $display("FAIL reset_valid got=%b exp=0", bus.o_RESULT_VALID);
    end
    vectors++;
    if (observed() !== 7'h00) begin
      miscompares++; $display("FAIL reset_result got=%h exp=00", observed());
    end
    vectors++;
    if (bus.o_START_READY !== 1'b1) begin
      miscompares++; $display("FAIL reset_start_ready got=%b exp=1", bus.o_START_READY);
    end
    vectors++;
    if (bus.o_BUSY !== 1'b0) begin
      miscompares++; $display("FAIL reset_busy got=%b exp=0", bus.o_BUSY);
    end
  endtask

  task automatic test_directed();
    logic [DW-1:0] ta [4] = '{16'h8000, 16'h1234, 16'hBEEF, 16'h00F0};
    logic [DW-1:0] tb [4] = '{16'h0000, 16'h1235, 16'hBEEF, 16'h00E0};
    bit            tsc[4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    logic [6:0]    tex[4] = '{7'h4F, 7'h20, 7'h10, 7'h44};
`ifdef FBC_EARLY_EXIT_EN
    int            tlat[4] = '{1, 4, 4, 3};
`else
    int            tlat[4] = '{4, 4, 4, 4};
`endif
    logic [6:0] got;
    int lat;
    bit tmo;
    for (int i = 0; i < 4; i++) begin
      drive_txn(ta[i], tb[i], tsc[i], got, lat, tmo);
      vectors++;
      if (tmo !== 1'b0) begin
        miscompares++; $display("FAIL directed%0d_timeout got=1 exp=0", i);
      end
      vectors++;
      if (got !== tex[i]) begin
        miscompares++; $display("FAIL directed%0d_result got=%h exp=%h", i, got, tex[i]);
      end
      vectors++;
      if (lat !== tlat[i]) begin
        miscompares++; $display("FAIL directed%0d_latency got=%0d exp=%0d", i, lat, tlat[i]);
      end
      vectors++;
      if (bus.o_START_READY !== 1'b1 || bus.o_RESULT_VALID !== 1'b0 || observed() !== 7'h00) begin
        miscompares++;
        $display("FAIL directed%0d_idle_after got=rdy%b vld%b res%h exp=rdy1 vld0 res00",
                 i, bus.o_START_READY, bus.o_RESULT_VALID, observed());
      end
    end
  endtask

  task automatic test_random();
    logic [DW-1:0] a, b;
    logic [6:0] got, exp;
    int lat, elat, mode;
    bit tmo;
    for (int i = 0; i < 40; i++) begin
      a    = 16'($urandom);
      mode = $urandom_range(0, 3);
      case (mode)
        0: b = 16'($urandom);
        1: b = a;
        2: b = a ^ (16'h1 << $urandom_range(0, DW - 1));
        default: b = a ^ (16'($urandom_range(1, 15)) << (4 * $urandom_range(0, NIB - 1)));
      endcase
      exp_q.push_back(model(a, b));
      elat = model_lat(a, b);
      drive_txn(a, b, $urandom_range(0, 1) == 1, got, lat, tmo);
      exp = exp_q.pop_front();
      vectors++;
      if (tmo !== 1'b0 || got !== exp) begin
        miscompares++;
        $display("FAIL random%0d_result a=%h b=%h got=%h tmo=%b exp=%h", i, a, b, got, tmo, exp);
      end
      vectors++;
      if (lat !== elat) begin
        miscompares++; $display("FAIL random%0d_latency a=%h b=%h got=%0d exp=%0d", i, a, b, lat, elat);
      end
    end
  endtask

  task automatic test_backpressure();
    int w;
    bit held_ok, rdy_ok;
    held_ok = 1'b1;
    rdy_ok  = 1'b1;
    bus.i_OPERAND_A    = 16'h0010;
    bus.i_OPERAND_B    = 16'h0100;
    bus.i_RESULT_READY = 1'b0;
    bus.i_START_VALID  = 1'b1;
    @(negedge clk);
    bus.i_START_VALID = 1'b0;
    w = 0;
    while (!bus.o_RESULT_VALID && w < 20) begin @(negedge clk); w++; end
    vectors++;
    if (bus.o_RESULT_VALID !== 1'b1 || observed() !== 7'h28) begin
      miscompares++;
      $display("FAIL bp_result got=vld%b res%h exp=vld1 res28", bus.o_RESULT_VALID, observed());
    end
    for (int c = 0; c < 5; c++) begin
      if (c == 2) begin
        bus.i_OPERAND_A   = 16'hFFFF;
        bus.i_OPERAND_B   = 16'h0000;
        bus.i_START_VALID = 1'b1;
      end else begin
        bus.i_START_VALID = 1'b0;
      end
      @(negedge clk);
      if (bus.o_RESULT_VALID !== 1'b1 || observed() !== 7'h28) held_ok = 1'b0;
      if (bus.o_START_READY !== 1'b0) rdy_ok = 1'b0;
    end
    bus.i_START_VALID = 1'b0;
    vectors++;
    if (held_ok !== 1'b1) begin
      miscompares++; $display("FAIL bp_hold got=changed exp=res28 held valid");
    end
    vectors++;
    if (rdy_ok !== 1'b1) begin
      miscompares++; $display("FAIL bp_start_ready got=1_seen exp=0");
    end
    bus.i_RESULT_READY = 1'b1;
    @(negedge clk);
    vectors++;
    if (bus.o_START_READY !== 1'b1 || bus.o_RESULT_VALID !== 1'b0 || bus.o_BUSY !== 1'b0) begin
      miscompares++;
      $display("FAIL bp_release got=rdy%b vld%b busy%b exp=rdy1 vld0 busy0",
               bus.o_START_READY, bus.o_RESULT_VALID, bus.o_BUSY);
    end
    // The ignored pulse must not have queued a scan
    @(negedge clk);
    vectors++;
    if (bus.o_BUSY !== 1'b0) begin
      miscompares++; $display("FAIL bp_no_ghost_start got=busy1 exp=busy0");
    end
  endtask

  task automatic test_reset_midscan();
    logic [6:0] got;
    int lat;
    bit tmo, seen;
    bus.i_OPERAND_A    = 16'hFFFF;
    bus.i_OPERAND_B    = 16'hFFFE;
    bus.i_RESULT_READY = 1'b1;
    bus.i_START_VALID  = 1'b1;
    @(negedge clk);
    bus.i_START_VALID = 1'b0;
    @(negedge clk);              // second SCAN cycle in progress
    rst_n = 1'b0;
    #1;
    vectors++;
    if (bus.o_RESULT_VALID !== 1'b0 || observed() !== 7'h00 || bus.o_BUSY !== 1'b0
        || bus.o_START_READY !== 1'b1) begin
      miscompares++;
      $display("FAIL midreset_outputs got=vld%b res%h busy%b rdy%b exp=vld0 res00 busy0 rdy1",
               bus.o_RESULT_VALID, observed(), bus.o_BUSY, bus.o_START_READY);
    end
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (bus.o_RESULT_VALID || bus.o_BUSY) seen = 1'b1;
    end
    vectors++;
    if (seen !== 1'b0) begin
      miscompares++; $display("FAIL midreset_no_result got=activity exp=none");
    end
    drive_txn(16'h0001, 16'h0000, 1'b0, got, lat, tmo);
    vectors++;
    if (tmo !== 1'b0 || got !== 7'h40) begin
      miscompares++; $display("FAIL midreset_fresh got=%h tmo=%b exp=40", got, tmo);
    end
  endtask

  task automatic test_back_to_back();
    int acc[$];
    int w, gap, egap;
    bit res_ok;
    res_ok = 1'b1;
    bus.i_OPERAND_A    = 16'h1234;
    bus.i_OPERAND_B    = 16'h1235;
    bus.i_RESULT_READY = 1'b1;
    bus.i_START_VALID  = 1'b1;
    for (int c = 0; c < 30; c++) begin
      if (bus.o_START_READY) acc.push_back(c);
      if (bus.o_RESULT_VALID && observed() !== 7'h20) res_ok = 1'b0;
      @(negedge clk);
    end
    bus.i_START_VALID = 1'b0;
    w = 0;
    while (bus.o_BUSY && w < 20) begin @(negedge clk); w++; end
    egap = model_lat(16'h1234, 16'h1235) + 2;
    gap  = (acc.size() >= 2) ? acc[1] - acc[0] : -1;
    vectors++;
    if (gap !== egap) begin
      miscompares++; $display("FAIL b2b_spacing got=%0d exp=%0d", gap, egap);
    end
    vectors++;
    if (res_ok !== 1'b1) begin
      miscompares++; $display("FAIL b2b_result got=wrong exp=20");
    end
    vectors++;
    if (bus.o_BUSY !== 1'b0) begin
      miscompares++; $display("FAIL b2b_drain got=busy1 exp=busy0");
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n              = 1'b0;
    bus.i_START_VALID  = 1'b0;
    bus.i_OPERAND_A    = '0;
    bus.i_OPERAND_B    = '0;
    bus.i_RESULT_READY = 1'b0;
    @(negedge clk);
    test_reset();
    test_directed();
    test_random();
    test_backpressure();
    test_reset_midscan();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
